// File: rtl/crc8_pkg.sv
// Shared CRC-8 (poly x^8+x^2+x+1, MSB first) byte update.
package crc8_pkg;

    function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data, input logic [7:0] crc);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_pkg.sv
// Shared S3G framing constants and receiver state encoding.
package s3g_pkg;

    localparam int         MAX_PAYLOAD = 16;
    localparam logic [7:0] MAX_LEN     = 8'd16;
    localparam logic [7:0] START_BYTE  = 8'hD5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CRC  = 2'd3
    } s3g_state_e;

endpackage

// File: rtl/s3g_rx_timeout.sv
// Inter-byte watchdog: down-counter reloaded on clear, expires at terminal count zero.
module s3g_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= CW'(TIMEOUT_CYCLES - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A byte arriving on the expiry cycle suppresses the timeout.
    assign o_expire = (r_cnt == '0) && !i_clear;

endmodule

// File: rtl/s3g_rx.sv
// S3G packet receiver: frames UART bytes, checks CRC-8, commits payload to output registers.
//   state  | meaning
//   S_IDLE | hunting for start byte
//   S_LEN  | expecting length byte
//   S_DATA | collecting payload into shadow buffer
//   S_CRC  | expecting CRC byte, commit or drop
module s3g_rx
    import s3g_pkg::*;
    import crc8_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       packet_rd,
    output logic [7:0] payload_len,
    output logic [7:0] buf0,
    output logic [7:0] buf1,
    output logic [7:0] buf2,
    output logic [7:0] buf3,
    output logic [7:0] buf4,
    output logic [7:0] buf5,
    output logic [7:0] buf6,
    output logic [7:0] buf7,
    output logic [7:0] buf8,
    output logic [7:0] buf9,
    output logic [7:0] buf10,
    output logic [7:0] buf11,
    output logic [7:0] buf12,
    output logic [7:0] buf13,
    output logic [7:0] buf14,
    output logic [7:0] buf15,
    output logic       busy,
    output logic       crc_err,
    output logic       len_err,
    output logic       timeout_err
);

    s3g_state_e r_state;
    logic [4:0] r_len;
    logic [4:0] r_byte_cnt;
    logic [7:0] r_crc;
    logic [7:0] r_shadow [MAX_PAYLOAD];
    logic [7:0] r_buf    [MAX_PAYLOAD];
    logic [7:0] r_payload_len;
    logic       r_commit_pend;
    logic       r_packet_rd;
    logic       r_crc_err;
    logic       r_len_err;
    logic       r_timeout_err;

    logic w_tmo_clear;
    logic w_expire;
    logic w_last;

    assign w_tmo_clear = rx_done || (r_state == S_IDLE);
    assign w_last      = ((r_byte_cnt + 5'd1) == r_len);

    s3g_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmo_clear),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_byte_cnt    <= '0;
            r_crc         <= '0;
            r_payload_len <= '0;
            r_commit_pend <= 1'b0;
            r_packet_rd   <= 1'b0;
            r_crc_err     <= 1'b0;
            r_len_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                r_shadow[i] <= '0;
                r_buf[i]    <= '0;
            end
        end else begin
            r_packet_rd   <= 1'b0;
            r_crc_err     <= 1'b0;
            r_len_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_commit_pend <= 1'b0;

            // Commit reads the shadow before any same-edge clear by a new start byte.
            if (r_commit_pend) begin
                r_packet_rd   <= 1'b1;
                r_payload_len <= {3'b000, r_len};
                for (int i = 0; i < MAX_PAYLOAD; i++) begin
                    r_buf[i] <= r_shadow[i];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_done && rx_data == START_BYTE) begin
                        r_state <= S_LEN;
                        for (int i = 0; i < MAX_PAYLOAD; i++) begin
                            r_shadow[i] <= '0;
                        end
                    end
                end
                S_LEN: begin
                    if (rx_done) begin
                        if (rx_data > MAX_LEN) begin
                            r_len_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_len      <= rx_data[4:0];
                            r_byte_cnt <= '0;
                            r_crc      <= '0;
                            r_state    <= (rx_data == 8'd0) ? S_CRC : S_DATA;
                        end
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (rx_done) begin
                        r_shadow[r_byte_cnt[3:0]] <= rx_data;
                        r_crc      <= nextCRC8_D8(rx_data, r_crc);
                        r_byte_cnt <= r_byte_cnt + 5'd1;
                        if (w_last) begin
                            r_state <= S_CRC;
                        end
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_CRC: begin
                    if (rx_done) begin
                        r_state <= S_IDLE;
                        if (rx_data == r_crc) begin
                            r_commit_pend <= 1'b1;
                        end else begin
                            r_crc_err <= 1'b1;
                        end
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign packet_rd   = r_packet_rd;
    assign crc_err     = r_crc_err;
    assign len_err     = r_len_err;
    assign timeout_err = r_timeout_err;
    assign payload_len = r_payload_len;

    assign buf0  = r_buf[0];
    assign buf1  = r_buf[1];
    assign buf2  = r_buf[2];
    assign buf3  = r_buf[3];
    assign buf4  = r_buf[4];
    assign buf5  = r_buf[5];
    assign buf6  = r_buf[6];
    assign buf7  = r_buf[7];
    assign buf8  = r_buf[8];
    assign buf9  = r_buf[9];
    assign buf10 = r_buf[10];
    assign buf11 = r_buf[11];
    assign buf12 = r_buf[12];
    assign buf13 = r_buf[13];
    assign buf14 = r_buf[14];
    assign buf15 = r_buf[15];

endmodule

// File: tb/tb_s3g_rx.sv
// Scoreboard bench for s3g_rx: expected packet/error events queued at stimulus, matched on output pulses.
module tb_s3g_rx;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       packet_rd, busy, crc_err, len_err, timeout_err;
    logic [7:0] payload_len;
    logic [7:0] buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7;
    logic [7:0] buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15;
    logic [7:0] w_bufs [16];

    s3g_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .packet_rd(packet_rd), .payload_len(payload_len),
        .buf0(buf0), .buf1(buf1), .buf2(buf2), .buf3(buf3),
        .buf4(buf4), .buf5(buf5), .buf6(buf6), .buf7(buf7),
        .buf8(buf8), .buf9(buf9), .buf10(buf10), .buf11(buf11),
        .buf12(buf12), .buf13(buf13), .buf14(buf14), .buf15(buf15),
        .busy(busy), .crc_err(crc_err), .len_err(len_err), .timeout_err(timeout_err)
    );

    assign w_bufs[0]  = buf0;  assign w_bufs[1]  = buf1;  assign w_bufs[2]  = buf2;  assign w_bufs[3]  = buf3;
    assign w_bufs[4]  = buf4;  assign w_bufs[5]  = buf5;  assign w_bufs[6]  = buf6;  assign w_bufs[7]  = buf7;
    assign w_bufs[8]  = buf8;  assign w_bufs[9]  = buf9;  assign w_bufs[10] = buf10; assign w_bufs[11] = buf11;
    assign w_bufs[12] = buf12; assign w_bufs[13] = buf13; assign w_bufs[14] = buf14; assign w_bufs[15] = buf15;

    always #5 clk = ~clk;

    localparam int K_PKT = 0, K_CRC = 1, K_LEN = 2, K_TMO = 3;

    typedef struct {
        int         kind;
        int         len;
        logic [7:0] d [16];
    } exp_t;

    exp_t       sb_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         last_len = 0;
    logic [7:0] last_d [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_crc(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    // Monitor: every output pulse must match the oldest queued expectation.
    exp_t e_mon;
    int   npulse, got_kind;
    always @(negedge clk) begin
        if (rst_n) begin
            npulse = int'(packet_rd) + int'(crc_err) + int'(len_err) + int'(timeout_err);
            if (npulse > 0) begin
                chk("pulse_excl", npulse, 1);
                got_kind = packet_rd ? K_PKT : crc_err ? K_CRC : len_err ? K_LEN : K_TMO;
                if (sb_q.size() == 0) begin
                    chk("unexpected_evt", got_kind, 32'hFFFF_FFFF);
                end else begin
                    e_mon = sb_q.pop_front();
                    chk("evt_kind", got_kind, e_mon.kind);
                    if (got_kind == K_PKT) begin
                        last_len = e_mon.len;
                        for (int i = 0; i < 16; i++) last_d[i] = e_mon.d[i];
                    end
                    chk("out_len", payload_len, last_len);
                    for (int i = 0; i < 16; i++) chk($sformatf("out_buf%0d", i), w_bufs[i], last_d[i]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_packet(input int len, input logic [7:0] d [16], input bit bad);
        exp_t       e;
        logic [7:0] c;
        c = 8'h00;
        e.kind = bad ? K_CRC : K_PKT;
        e.len  = len;
        for (int i = 0; i < 16; i++) e.d[i] = (i < len) ? d[i] : 8'h00;
        for (int i = 0; i < len; i++) c = model_crc(c, d[i]);
        send_byte(8'hD5);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) send_byte(d[i]);
        sb_q.push_back(e);
        send_byte(bad ? (c ^ 8'h5A) : c);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        chk(tag, sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d [16];
        exp_t       e;
        logic [7:0] c;

        for (int i = 0; i < 16; i++) last_d[i] = 8'h00;
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_len", payload_len, 0);
        chk("rst_buf0", buf0, 0);
        chk("rst_pulses", {packet_rd, crc_err, len_err, timeout_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Noise bytes then an empty packet.
        send_byte(8'hAA);
        send_byte(8'h55);
        chk("noise_idle", busy, 0);
        for (int i = 0; i < 16; i++) d[i] = 8'h00;
        send_packet(0, d, 1'b0);
        drain("drain_len0");

        // 3-byte packet with exact commit latency.
        d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
        send_packet(3, d, 1'b0);
        chk("rd_lat0", packet_rd, 0);
        @(negedge clk);
        chk("rd_lat1", packet_rd, 1);
        drain("drain_p3");

        // Full-size packet immediately followed by a bad-CRC packet.
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        d[5] = 8'hD5;
        send_packet(16, d, 1'b0);
        d[0] = 8'h10; d[1] = 8'h20;
        send_packet(2, d, 1'b1);
        drain("drain_b2b");

        // Oversize length.
        send_byte(8'hD5);
        e.kind = K_LEN; e.len = 0;
        for (int i = 0; i < 16; i++) e.d[i] = 8'h00;
        sb_q.push_back(e);
        send_byte(8'h11);
        chk("len_busy", busy, 0);
        d[0] = 8'h77;
        send_packet(1, d, 1'b0);
        drain("drain_lenerr");

        // Byte coincident with timeout expiry wins.
        send_byte(8'hD5);
        send_byte(8'h02);
        send_byte(8'hAA);
        repeat (TMO - 1) @(negedge clk);
        chk("ext_busy", busy, 1);
        send_byte(8'hBB);
        c = model_crc(model_crc(8'h00, 8'hAA), 8'hBB);
        e.kind = K_PKT; e.len = 2;
        for (int i = 0; i < 16; i++) e.d[i] = 8'h00;
        e.d[0] = 8'hAA; e.d[1] = 8'hBB;
        sb_q.push_back(e);
        send_byte(c);
        drain("drain_ext");

        // Real timeout.
        send_byte(8'hD5);
        send_byte(8'h02);
        send_byte(8'hAA);
        e.kind = K_TMO; e.len = 0;
        sb_q.push_back(e);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_busy49", busy, 1);
        @(negedge clk);
        chk("tmo_busy50", busy, 0);
        drain("drain_tmo");

        // Asynchronous reset in the middle of payload.
        send_byte(8'hD5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_len", payload_len, 0);
        chk("arst_buf0", buf0, 0);
        last_len = 0;
        for (int i = 0; i < 16; i++) last_d[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("arst_nostart", busy, 0);
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        send_packet(5, d, 1'b0);
        drain("drain_arst");

        // Random mix.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
            send_packet(int'($urandom_range(0, 16)), d, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("drain_rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/s3g_rx.md
S3G_RX -- requirements
Module: s3g_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, idle clk cycles allowed between bytes inside a packet before abort.
REQ-002 clk  input  1  sole clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  byte from UART receiver, valid when rx_done=1.
REQ-005 rx_done  input  1  one-cycle strobe per received byte.
REQ-006 packet_rd  output  1  one-cycle pulse: a CRC-valid packet was committed to payload_len/buf0..buf15.
REQ-007 payload_len  output  8  length of last committed packet (0..16).
REQ-008 buf0..buf15  output  8 each  payload bytes of last committed packet; bytes at index >= payload_len are 0x00.
REQ-009 busy  output  1  high while a packet is being received (any state except S_IDLE).
REQ-010 crc_err  output  1  one-cycle pulse: CRC byte mismatch, packet dropped.
REQ-011 len_err  output  1  one-cycle pulse: length byte > 16, packet dropped.
REQ-012 timeout_err  output  1  one-cycle pulse: inter-byte timeout, packet dropped.

Function
REQ-013 Packet format: 0xD5 start, length L, L payload bytes, CRC-8 byte; no escaping.
REQ-014 CRC: shared crc8 function nextCRC8_D8(data, crc), init 0x00, over payload bytes only, no final XOR.
REQ-015 States S_IDLE, S_LEN, S_DATA, S_CRC; any unused encoding returns to S_IDLE next cycle.
REQ-016 S_IDLE: rx_done with 0xD5 -> S_LEN; any other byte ignored, no error.
REQ-017 S_LEN: rx_done -> if L>16 pulse len_err, -> S_IDLE; if L=0 -> S_CRC; else -> S_DATA; byte_cnt and crc cleared, L saved.
REQ-018 S_DATA: each rx_done writes byte to shadow buffer[byte_cnt], updates crc, increments byte_cnt; after byte L-1 -> S_CRC. 0xD5 is ordinary data here.
REQ-019 S_CRC: rx_done -> S_IDLE; if rx_data==crc commit, else pulse crc_err; outputs untouched on error.
REQ-020 Commit: on the edge after the clock edge sampling the CRC rx_done, payload_len<=L, buf0..buf15<=shadow (zeros above L), packet_rd=1 for exactly one cycle; latency 1 cycle.
REQ-021 Shadow buffer cleared to 0x00 on entry to S_LEN so stale bytes never commit.
REQ-022 Timeout counter clears on every rx_done and in S_IDLE; at TIMEOUT_CYCLES without rx_done outside S_IDLE pulse timeout_err, -> S_IDLE.
REQ-023 rx_done coincident with timeout expiry: byte wins, counter clears, no error.
REQ-024 Error pulses and packet_rd mutually exclusive; at most one per packet.
REQ-025 Back-to-back packets: a 0xD5 arriving the cycle after S_CRC exit is accepted as new start.

Reset
REQ-026 rst_n low asynchronously forces S_IDLE; byte_cnt, crc, timeout counter, shadow = 0.
REQ-027 Reset values: packet_rd=0, busy=0, crc_err=0, len_err=0, timeout_err=0, payload_len=0x00, buf0..buf15=0x00.
REQ-028 Reset mid-packet discards partial packet, no error pulse; release requires fresh 0xD5.

Structure
REQ-029 State encodings, max payload 16, start byte 0xD5 live in shared s3g_pkg package, also used by s3g transmitter.
REQ-030 crc8 function in shared crc8 package, not duplicated.
REQ-031 No sub-module required; optional s3g_rx_timeout counter sub-module.

Verification
REQ-032 D5 03 01 02 03 crc(01 02 03) -> packet_rd one cycle after CRC strobe, payload_len=3, buf0..buf2=01,02,03, buf3..buf15=00.
REQ-033 D5 00 00 -> packet_rd, payload_len=0, all buf=00; AA 55 preceding D5 ignored.
REQ-034 D5 02 10 20 with wrong CRC -> crc_err pulse, no packet_rd, outputs keep previous packet.
REQ-035 D5 11 -> len_err on length byte, busy falls; following valid packet accepted normally.
REQ-036 TIMEOUT_CYCLES=50: D5 02 AA then 50 idle cycles -> timeout_err, S_IDLE; byte at cycle 49 extends instead.
REQ-037 rst_n low during S_DATA -> all outputs reset asynchronously, no pulses; next full packet commits.
